// File: rtl/qpi_mem_arbiter.sv
// Two-port burst arbiter in front of one QPI memory port.
// Grants whole bursts round-robin (or fixed priority) and waits for memory idle on release.
module qpi_mem_arbiter #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_do_read,
    input  logic          m0_do_write,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_next_word,
    output logic          m0_is_idle,
    input  logic          m1_do_read,
    input  logic          m1_do_write,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_next_word,
    output logic          m1_is_idle,
    output logic          s_do_read,
    output logic          s_do_write,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_next_word,
    input  logic          s_is_idle
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   owner, owner_nx;
    logic   rr_ptr, rr_nx;
    logic   req0, req1;
    logic   pick;
    logic   g0, g1;

    assign req0 = m0_do_read | m0_do_write;
    assign req1 = m1_do_read | m1_do_write;
    assign g0   = (state == GRANT0);
    assign g1   = (state == GRANT1);

    // State, owner and round-robin pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            rr_ptr <= rr_nx;
        end
    end

    // Arbitration choice and next-state logic
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_nx    = rr_ptr;
        pick     = 1'b0;
        if (req0 && req1) begin
            pick = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr;
        end else begin
            pick = req1;
        end
        unique case (state)
            IDLE: begin
                if (s_is_idle && (req0 || req1)) begin
                    state_nx = pick ? GRANT1 : GRANT0;
                    owner_nx = pick;
                end
            end
            GRANT0: begin
                if (!req0) begin
                    state_nx = RELEASE;
                    rr_nx    = 1'b1;
                end
            end
            GRANT1: begin
                if (!req1) begin
                    state_nx = RELEASE;
                    rr_nx    = 1'b0;
                end
            end
            RELEASE: begin
                if (s_is_idle) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Steer the granted requester onto the memory port; read beats write
    always_comb begin
        s_do_read  = (g0 & m0_do_read) | (g1 & m1_do_read);
        s_do_write = (g0 & m0_do_write & ~m0_do_read)
                   | (g1 & m1_do_write & ~m1_do_read);
        s_addr     = '0;
        s_wdata    = '0;
        if (g0) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
        end else if (g1) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end
    end

    // Return strobes to the owner only; idle reflects grant and pending release
    always_comb begin
        m0_rdata     = s_rdata;
        m1_rdata     = s_rdata;
        m0_next_word = g0 & s_next_word;
        m1_next_word = g1 & s_next_word;
        m0_is_idle   = ~(g0 | ((state == RELEASE) & ~owner));
        m1_is_idle   = ~(g1 | ((state == RELEASE) & owner));
    end

endmodule

// File: tb/tb_qpi_mem_arbiter.sv
// Bench for qpi_mem_arbiter: arbitration vector table, beat scoreboard,
// busy-memory, async reset and fixed-priority sequences.
module tb_qpi_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_do_read, m0_do_write;
    logic [23:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m0_next_word, m0_is_idle;
    logic        m1_do_read, m1_do_write;
    logic [23:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        m1_next_word, m1_is_idle;
    logic        s_do_read, s_do_write;
    logic [23:0] s_addr;
    logic [31:0] s_wdata, s_rdata;
    logic        s_next_word, s_is_idle;

    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_m0_next_word, fp_m0_is_idle;
    logic        fp_m1_next_word, fp_m1_is_idle;
    logic        fp_s_do_read, fp_s_do_write;
    logic [23:0] fp_s_addr;
    logic [31:0] fp_s_wdata;

    int checks   = 0;
    int failures = 0;

    qpi_mem_arbiter #(.AW(24), .DW(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .m0_do_read(m0_do_read), .m0_do_write(m0_do_write),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m0_next_word(m0_next_word), .m0_is_idle(m0_is_idle),
        .m1_do_read(m1_do_read), .m1_do_write(m1_do_write),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .m1_next_word(m1_next_word), .m1_is_idle(m1_is_idle),
        .s_do_read(s_do_read), .s_do_write(s_do_write),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_next_word(s_next_word), .s_is_idle(s_is_idle)
    );

    qpi_mem_arbiter #(.AW(24), .DW(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_do_read(m0_do_read), .m0_do_write(m0_do_write),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(fp_m0_rdata),
        .m0_next_word(fp_m0_next_word), .m0_is_idle(fp_m0_is_idle),
        .m1_do_read(m1_do_read), .m1_do_write(m1_do_write),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(fp_m1_rdata),
        .m1_next_word(fp_m1_next_word), .m1_is_idle(fp_m1_is_idle),
        .s_do_read(fp_s_do_read), .s_do_write(fp_s_do_write),
        .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_rdata(s_rdata),
        .s_next_word(s_next_word), .s_is_idle(s_is_idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        m0r, m0w, m1r, m1w;
        logic [23:0] a0, a1;
        logic [31:0] w0, w1;
        logic        eown, erd, ewr;
    } vec_t;

    typedef struct packed {
        logic        own;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];
    vec_t  vt[9];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic m0r, m0w, m1r, m1w,
                                input logic [23:0] a0, a1,
                                input logic eown, erd, ewr);
        vec_t v;
        v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w;
        v.a0 = a0; v.a1 = a1;
        v.w0 = {8'h50, a0}; v.w1 = {8'h51, a1};
        v.eown = eown; v.erd = erd; v.ewr = ewr;
        return v;
    endfunction

    // Scoreboard: every forwarded word must be an expected beat for the owner
    always @(negedge clk) begin
        if (rst && (m0_next_word || m1_next_word)) begin
            if (sb.size() == 0) begin
                chk("spurious_next_word", {62'd0, m1_next_word, m0_next_word}, 64'd0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_owner", {62'd0, m1_next_word, m0_next_word},
                    e.own ? 64'd2 : 64'd1);
                chk("beat_rdata", e.own ? m1_rdata : m0_rdata, {32'd0, e.data});
            end
        end
    end

    task automatic clear_reqs();
        m0_do_read = 0; m0_do_write = 0;
        m1_do_read = 0; m1_do_write = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        tick();
        m0_do_read = v.m0r; m0_do_write = v.m0w;
        m1_do_read = v.m1r; m1_do_write = v.m1w;
        m0_addr = v.a0; m1_addr = v.a1;
        m0_wdata = v.w0; m1_wdata = v.w1;
        mid();
        chk("latency_do", {62'd0, s_do_read, s_do_write}, 64'd0);
        tick();
        mid();
        chk("grant_rd", s_do_read, v.erd);
        chk("grant_wr", s_do_write, v.ewr);
        chk("grant_addr", s_addr, v.eown ? v.a1 : v.a0);
        chk("grant_wdata", s_wdata, v.eown ? v.w1 : v.w0);
        chk("grant_idle0", m0_is_idle, v.eown);
        chk("grant_idle1", m1_is_idle, !v.eown);
        for (int b = 0; b < 4; b++) begin
            tick();
            s_next_word = 1'b1;
            s_rdata = 32'hA0 + 32'(idx * 16) + 32'(b);
            sb.push_back('{own: v.eown, data: s_rdata});
            mid();
        end
        tick();
        clear_reqs();
        s_next_word = 1'b0;
        mid();
        chk("drop_do", {62'd0, s_do_read, s_do_write}, 64'd0);
        tick();
        s_next_word = 1'b1;
        s_rdata = 32'hDEAD;
        mid();
        chk("release_owner_busy", v.eown ? m1_is_idle : m0_is_idle, 64'd0);
        chk("release_addr", s_addr, 64'd0);
        tick();
        s_next_word = 1'b0;
        mid();
        chk("back_idle", {62'd0, m0_is_idle, m1_is_idle}, 64'd3);
    endtask

    initial begin
        rst = 0;
        clear_reqs();
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        s_rdata = 32'h1234; s_next_word = 1; s_is_idle = 1;

        vt[0] = mk(1,0,0,0, 24'h001000, 24'h000000, 0, 1, 0);
        vt[1] = mk(0,1,1,0, 24'h002000, 24'h003000, 1, 1, 0);
        vt[2] = mk(0,1,1,0, 24'h004000, 24'h005000, 0, 0, 1);
        vt[3] = mk(0,1,1,0, 24'h006000, 24'h007000, 1, 1, 0);
        vt[4] = mk(0,1,1,0, 24'h008000, 24'h009000, 0, 0, 1);
        vt[5] = mk(0,0,1,1, 24'h00A000, 24'h00B000, 1, 1, 0);
        vt[6] = mk(1,1,0,0, 24'h00C000, 24'h00D000, 0, 1, 0);
        vt[7] = mk(0,0,0,1, 24'h00E000, 24'h00F000, 1, 0, 1);
        vt[8] = mk(1,0,0,1, 24'h010000, 24'h011000, 0, 1, 0);

        tick();
        tick();
        mid();
        chk("rst_s_do", {62'd0, s_do_read, s_do_write}, 64'd0);
        chk("rst_s_addr", s_addr, 64'd0);
        chk("rst_s_wdata", s_wdata, 64'd0);
        chk("rst_next_word", {62'd0, m0_next_word, m1_next_word}, 64'd0);
        chk("rst_is_idle", {62'd0, m0_is_idle, m1_is_idle}, 64'd3);
        tick();
        s_next_word = 0;
        rst = 1;
        mid();

        for (int i = 0; i < 9; i++) begin
            run_vec(vt[i], i);
        end

        // Memory busy: no grant until idle, then grant one cycle later
        tick();
        s_is_idle = 0;
        m1_do_write = 1; m1_addr = 24'h00BEEF; m1_wdata = 32'hCAFE0001;
        for (int c = 0; c < 10; c++) begin
            mid();
            chk("busy_no_do", {62'd0, s_do_read, s_do_write}, 64'd0);
            tick();
        end
        s_is_idle = 1;
        mid();
        chk("busy_rise_no_do", s_do_write, 64'd0);
        tick();
        mid();
        chk("busy_grant_wr", s_do_write, 64'd1);
        chk("busy_grant_addr", s_addr, 64'h00BEEF);
        tick();
        m1_do_write = 0;
        s_is_idle = 0;
        mid();
        chk("busy_drop_do", s_do_write, 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            mid();
            chk("release_hold_m1", m1_is_idle, 64'd0);
            chk("release_hold_m0", m0_is_idle, 64'd1);
        end
        tick();
        s_is_idle = 1;
        mid();
        chk("release_last_m1", m1_is_idle, 64'd0);
        tick();
        mid();
        chk("release_done_m1", m1_is_idle, 64'd1);

        // Reset in the middle of a GRANT1 burst
        tick();
        m0_do_read = 1; m0_addr = 24'h000100;
        tick();
        m0_do_read = 0;
        tick();
        tick();
        m1_do_read = 1; m1_addr = 24'h000200;
        tick();
        mid();
        chk("pre_rst_grant1", s_addr, 64'h000200);
        tick();
        #2;
        rst = 0;
        s_next_word = 1;
        #1;
        chk("async_rst_do", {62'd0, s_do_read, s_do_write}, 64'd0);
        chk("async_rst_addr", s_addr, 64'd0);
        chk("async_rst_nw", {62'd0, m0_next_word, m1_next_word}, 64'd0);
        chk("async_rst_idle", {62'd0, m0_is_idle, m1_is_idle}, 64'd3);
        tick();
        s_next_word = 0;
        tick();
        rst = 1;
        m0_do_read = 1;
        tick();
        mid();
        chk("post_rst_rr0", s_addr, 64'h000100);
        tick();
        m0_do_read = 0;
        tick();
        tick();
        tick();
        mid();
        chk("post_rst_regrant1_addr", s_addr, 64'h000200);
        chk("post_rst_regrant1_rd", s_do_read, 64'd1);
        tick();
        clear_reqs();
        tick();
        tick();

        // Fixed priority against round-robin with both always requesting
        rst = 0;
        tick();
        rst = 1;
        m0_do_read = 1; m0_addr = 24'h0A0A0A; m0_wdata = 32'h0000F00D;
        m1_do_read = 1; m1_addr = 24'h0B0B0B;
        s_rdata = 32'h77;
        tick();
        mid();
        chk("fp_first_addr", fp_s_addr, 64'h0A0A0A);
        for (int r = 0; r < 4; r++) begin
            tick();
            m0_do_read = 0;
            tick();
            m0_do_read = 1;
            tick();
            tick();
            mid();
            chk("fp_round_addr", fp_s_addr, 64'h0A0A0A);
            chk("fp_round_do", {62'd0, fp_s_do_read, fp_s_do_write}, 64'd2);
            chk("fp_round_wdata", fp_s_wdata, 64'h0000F00D);
            chk("fp_round_m1_idle", fp_m1_is_idle, 64'd1);
            chk("fp_rdata_bcast", {fp_m0_rdata, fp_m1_rdata}, 64'h0000007700000077);
            chk("rr_round_addr", s_addr, 64'h0B0B0B);
        end
        tick();
        m0_do_read = 0;
        tick();
        tick();
        tick();
        mid();
        chk("fp_m1_when_m0_quiet", fp_s_addr, 64'h0B0B0B);
        chk("fp_m1_busy", fp_m1_is_idle, 64'd0);
        chk("fp_no_nw", {62'd0, fp_m0_next_word, fp_m1_next_word}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
